// File: rtl/gpio_key_event_scanner.sv
// Purpose : synchronise and debounce NUM_KEYS raw key lines, report level and lowest-pressed code, queue press/release events.
// Latency : key_in edge -> key_state 2 sync cycles + up to STABLE_SAMPLES ticks + 1; key_state -> evt_valid about 2 cycles.
// Backpres: evt_ready stalls the event FIFO; an event arriving while it is full and not popping is dropped and sets overflow.
// Ports   : clk/rst (sync, active high); key_in raw lines; key_state/any_pressed/key_code debounced view;
//           evt_valid/evt_data/evt_ready show-ahead event stream {press, index}; evt_count FIFO fill;
//           overflow sticky drop flag, cleared by ovf_clr (set wins on a tie).
module gpio_key_event_scanner #(
    parameter int NUM_KEYS       = 13,
    parameter bit ACTIVE_LOW     = 1'b0,
    parameter int TICK_DIV       = 50000,
    parameter int STABLE_SAMPLES = 4,
    parameter int FIFO_DEPTH     = 8,
    localparam int IDX_W         = $clog2(NUM_KEYS),
    localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                any_pressed,
    output logic [IDX_W-1:0]    key_code,
    output logic                evt_valid,
    output logic [IDX_W:0]      evt_data,
    input  logic                evt_ready,
    output logic [CNT_W-1:0]    evt_count,
    output logic                overflow,
    input  logic                ovf_clr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TCK_W = $clog2(TICK_DIV);

    // ---------------- input synchroniser ----------------
    logic [NUM_KEYS-1:0] sync1, sync2, lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    // Normalise so that 1 always means pressed from here on.
    assign lvl = sync2 ^ {NUM_KEYS{ACTIVE_LOW}};

    // ---------------- debounce sample tick ----------------
    logic [TCK_W-1:0] tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == TCK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // ---------------- per-key debounce ----------------
    logic [STABLE_SAMPLES-1:0] hist     [NUM_KEYS];
    logic [STABLE_SAMPLES-1:0] hist_nxt [NUM_KEYS];
    logic [NUM_KEYS-1:0]       rise, fall;

    // The decision uses the history including the sample taken on this
    // tick, so a level held for STABLE_SAMPLES ticks is accepted on the last.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            hist_nxt[k] = {hist[k][STABLE_SAMPLES-2:0], lvl[k]};
            rise[k]     = tick & (&hist_nxt[k]) & ~key_state[k];
            fall[k]     = tick & ~(|hist_nxt[k]) & key_state[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_KEYS; k++) hist[k] <= '0;
            key_state <= '0;
        end else if (tick) begin
            for (int k = 0; k < NUM_KEYS; k++) hist[k] <= hist_nxt[k];
            key_state <= (key_state | rise) & ~fall;
        end
    end

    // ---------------- event serialiser ----------------
    logic [NUM_KEYS-1:0] pending;
    logic                sel_vld;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W:0]      push_dat;

    // Scan from the top down so the lowest set index is the last to win.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pending[k]) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(k);
            end
        end
    end

    // key_state[k] already holds the new level by the time pending[k] is seen.
    assign push_dat = {key_state[sel_idx], sel_idx};

    // New changes only arrive on a tick, and TICK_DIV leaves enough cycles
    // to drain every pending bit before the next one.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~(sel_vld ? (NUM_KEYS'(1) << sel_idx) : '0)) | rise | fall;
    end

    // ---------------- show-ahead event FIFO ----------------
    logic [IDX_W:0]   mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             full, pop, wr_en, ovf_set;

    assign evt_count = wr_ptr - rd_ptr;
    assign evt_valid = (evt_count != '0);
    assign full      = (evt_count == CNT_W'(FIFO_DEPTH));
    assign pop       = evt_valid & evt_ready;
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    assign wr_en     = sel_vld & (~full | pop);
    assign ovf_set   = sel_vld & full & ~pop;
    assign evt_data  = evt_valid ? mem[rd_ptr[PTR_W-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)        wr_ptr   <= wr_ptr + 1'b1;
            if (pop)          rd_ptr   <= rd_ptr + 1'b1;
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // ---------------- status view ----------------
    always_comb begin
        key_code = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (key_state[k]) key_code = IDX_W'(k);
        end
    end

    assign any_pressed = |key_state;

endmodule
